utf8_decoder: RTL and testbench

//  Streaming UTF-8 to Unicode scalar decoder. Consumes one byte per clock under a valid strobe.

---
 rtl/utf8_pkg.sv | 32 +++
 rtl/utf8_decoder_if.sv | 11 +
 rtl/utf8_byte_classifier.sv | 42 ++++
 rtl/utf8_decoder.sv | 112 +++++++++++
 tb/tb_utf8_decoder.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/utf8_pkg.sv
// rtl/utf8_pkg.sv - status codes, FSM states and second-byte range limits for the UTF-8 decoder
package utf8_pkg;

  localparam logic [1:0] ST_INITIAL = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_READY   = 2'd2;
  localparam logic [1:0] ST_ERROR   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEED1,
    S_NEED2,
    S_NEED3,
    S_ERR
  } state_e;

  localparam logic [7:0] CONT_LO = 8'h80;
  localparam logic [7:0] CONT_HI = 8'hBF;
  localparam logic [7:0] E0_LO   = 8'hA0;
  localparam logic [7:0] ED_HI   = 8'h9F;
  localparam logic [7:0] F0_LO   = 8'h90;
  localparam logic [7:0] F4_HI   = 8'h8F;

  function automatic state_e need_state(input logic [1:0] len);
    case (len)
      2'd1:    need_state = S_NEED1;
      2'd2:    need_state = S_NEED2;
      default: need_state = S_NEED3;
    endcase
  endfunction

endpackage

// File: rtl/utf8_decoder_if.sv
// rtl/utf8_decoder_if.sv - byte-in / code-point-out bundle between byte source and decoder
interface utf8_decoder_if;
  logic        allow;
  logic        finish;
  logic [7:0]  data;
  logic [20:0] code_point;
  logic [1:0]  status;

  modport master (output allow, output finish, output data, input code_point, input status);
  modport slave  (input allow, input finish, input data, output code_point, output status);
endinterface

// File: rtl/utf8_byte_classifier.sv
// rtl/utf8_byte_classifier.sv - combinational classification of one UTF-8 byte
module utf8_byte_classifier
  import utf8_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic       is_ascii_o,
  output logic       is_cont_o,
  output logic [1:0] lead_len_o,
  output logic [4:0] lead_payload_o,
  output logic       invalid_lead_o,
  output logic [7:0] sec_lo_o,
  output logic [7:0] sec_hi_o
);

  always_comb begin
    is_ascii_o     = ~byte_i[7];
    is_cont_o      = (byte_i[7:6] == 2'b10);
    lead_len_o     = 2'd0;
    lead_payload_o = 5'd0;
    invalid_lead_o = 1'b0;
    sec_lo_o       = CONT_LO;
    sec_hi_o       = CONT_HI;
    if (byte_i >= 8'hC2 && byte_i <= 8'hDF) begin
      lead_len_o     = 2'd1;
      lead_payload_o = byte_i[4:0];
    end else if (byte_i[7:4] == 4'hE) begin
      lead_len_o     = 2'd2;
      lead_payload_o = {1'b0, byte_i[3:0]};
      if (byte_i == 8'hE0) sec_lo_o = E0_LO;
      if (byte_i == 8'hED) sec_hi_o = ED_HI;
    end else if (byte_i >= 8'hF0 && byte_i <= 8'hF4) begin
      lead_len_o     = 2'd3;
      lead_payload_o = {2'b00, byte_i[2:0]};
      if (byte_i == 8'hF0) sec_lo_o = F0_LO;
      if (byte_i == 8'hF4) sec_hi_o = F4_HI;
    end else if (byte_i[7]) begin
      // stray continuation, overlong C0/C1, or beyond U+10FFFF
      invalid_lead_o = 1'b1;
    end
  end

endmodule

// File: rtl/utf8_decoder.sv
// rtl/utf8_decoder.sv - streaming UTF-8 decoder: input register stage, then decode FSM with registered outputs
module utf8_decoder
  import utf8_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  utf8_decoder_if.slave bus
);

  logic        s1_allow_q, s1_finish_q;
  logic [7:0]  s1_byte_q;
  state_e      state_q;
  logic [20:0] acc_q, code_point_q;
  logic [1:0]  status_q;
  logic [7:0]  lo_q, hi_q;

  logic       is_ascii, is_cont, invalid_lead;
  logic [1:0] lead_len;
  logic [4:0] lead_payload;
  logic [7:0] sec_lo, sec_hi;
  logic       cont_ok;

  utf8_byte_classifier u_cls (
    .byte_i         (s1_byte_q),
    .is_ascii_o     (is_ascii),
    .is_cont_o      (is_cont),
    .lead_len_o     (lead_len),
    .lead_payload_o (lead_payload),
    .invalid_lead_o (invalid_lead),
    .sec_lo_o       (sec_lo),
    .sec_hi_o       (sec_hi)
  );

  // lo/hi narrow only for the byte right after a lead, then relax to 80-BF
  assign cont_ok = is_cont && (s1_byte_q >= lo_q) && (s1_byte_q <= hi_q);

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_allow_q  <= 1'b0;
      s1_finish_q <= 1'b0;
      s1_byte_q   <= 8'h00;
    end else begin
      s1_allow_q  <= bus.allow;
      s1_finish_q <= bus.finish;
      s1_byte_q   <= bus.data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      acc_q        <= 21'd0;
      code_point_q <= 21'd0;
      status_q     <= ST_INITIAL;
      lo_q         <= CONT_LO;
      hi_q         <= CONT_HI;
    end else begin
      case (state_q)
        S_IDLE: begin
          status_q <= ST_INITIAL;
          if (s1_allow_q) begin
            if (is_ascii) begin
              code_point_q <= {13'd0, s1_byte_q};
              status_q     <= ST_READY;
            end else if (invalid_lead || is_cont) begin
              state_q  <= S_ERR;
              status_q <= ST_ERROR;
            end else begin
              state_q  <= need_state(lead_len);
              acc_q    <= {16'd0, lead_payload};
              lo_q     <= sec_lo;
              hi_q     <= sec_hi;
              status_q <= ST_PENDING;
            end
          end
        end
        S_NEED1, S_NEED2, S_NEED3: begin
          status_q <= ST_PENDING;
          if (s1_allow_q) begin
            if (!cont_ok || (s1_finish_q && state_q != S_NEED1)) begin
              state_q  <= S_ERR;
              status_q <= ST_ERROR;
            end else begin
              lo_q  <= CONT_LO;
              hi_q  <= CONT_HI;
              acc_q <= {acc_q[14:0], s1_byte_q[5:0]};
              if (state_q == S_NEED1) begin
                code_point_q <= {acc_q[14:0], s1_byte_q[5:0]};
                status_q     <= ST_READY;
                state_q      <= S_IDLE;
              end else begin
                state_q <= (state_q == S_NEED3) ? S_NEED2 : S_NEED1;
              end
            end
          end else if (s1_finish_q) begin
            state_q  <= S_ERR;
            status_q <= ST_ERROR;
          end
        end
        S_ERR: status_q <= ST_ERROR;
        default: begin
          state_q  <= S_IDLE;
          status_q <= ST_INITIAL;
        end
      endcase
    end
  end

  assign bus.code_point = code_point_q;
  assign bus.status     = status_q;

endmodule

// File: tb/tb_utf8_decoder.sv
// tb/tb_utf8_decoder.sv - table-driven and hand-sequenced checks of the UTF-8 decoder
module tb_utf8_decoder;

  typedef struct {
    logic        allow;
    logic        finish;
    logic [7:0]  data;
    logic [1:0]  exp_status;
    logic [20:0] exp_cp;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad = 0;
  vec_t vecs[$];

  utf8_decoder_if bus ();

  utf8_decoder dut (
    .clock (clk),
    .reset (rstn),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [20:0] act, input logic [20:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic a, input logic f, input logic [7:0] d);
    bus.allow  = a;
    bus.finish = f;
    bus.data   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 8'h41);
      chk("reset_status", {19'd0, bus.status}, 21'd0);
      chk("reset_cp", bus.code_point, 21'd0);
    end
    rstn = 1'b1;
  endtask

  function automatic void add(input logic a, input logic f, input logic [7:0] d,
                              input logic [1:0] st, input logic [20:0] cp);
    vec_t v;
    v.allow = a; v.finish = f; v.data = d; v.exp_status = st; v.exp_cp = cp;
    vecs.push_back(v);
  endfunction

  logic [7:0] bad_seq [6][4];
  int         bad_len [6];

  initial begin
    bus.allow = 1'b0; bus.finish = 1'b0; bus.data = 8'h00;

    // outputs after each edge reflect the byte applied one row earlier
    add(1, 0, 8'h41, 0, 21'h0);
    add(1, 0, 8'h42, 2, 21'h41);
    add(1, 0, 8'h0A, 2, 21'h42);
    add(1, 0, 8'hC3, 2, 21'h0A);
    add(1, 0, 8'hA9, 1, 21'h0A);
    add(1, 0, 8'hE2, 2, 21'hE9);
    add(1, 0, 8'h82, 1, 21'hE9);
    add(1, 0, 8'hAC, 1, 21'hE9);
    add(1, 0, 8'hF0, 2, 21'h20AC);
    add(1, 0, 8'h9F, 1, 21'h20AC);
    add(1, 0, 8'h98, 1, 21'h20AC);
    add(1, 0, 8'h80, 1, 21'h20AC);
    add(0, 0, 8'h00, 2, 21'h1F600);
    add(0, 0, 8'h00, 0, 21'h1F600);
    add(1, 0, 8'hE2, 0, 21'h1F600);
    add(0, 0, 8'h00, 1, 21'h1F600);
    add(0, 0, 8'h00, 1, 21'h1F600);
    add(0, 0, 8'h00, 1, 21'h1F600);
    add(1, 0, 8'h82, 1, 21'h1F600);
    add(0, 0, 8'h00, 1, 21'h1F600);
    add(1, 0, 8'hAC, 1, 21'h1F600);
    add(0, 0, 8'h00, 2, 21'h20AC);
    add(0, 0, 8'h00, 0, 21'h20AC);
    add(1, 1, 8'h41, 0, 21'h20AC);
    add(0, 0, 8'h00, 2, 21'h41);
    add(0, 1, 8'h00, 0, 21'h41);
    add(1, 0, 8'hE2, 0, 21'h41);
    add(1, 1, 8'h82, 1, 21'h41);
    add(0, 0, 8'h00, 3, 21'h41);
    add(1, 0, 8'h41, 3, 21'h41);
    add(0, 0, 8'h00, 3, 21'h41);
    add(0, 0, 8'h00, 3, 21'h41);

    do_reset();
    step(0, 0, 8'h00);
    chk("idle_no_ready", {19'd0, bus.status}, 21'd0);
    foreach (vecs[i]) begin
      step(vecs[i].allow, vecs[i].finish, vecs[i].data);
      chk($sformatf("vec%0d_status", i), {19'd0, bus.status}, {19'd0, vecs[i].exp_status});
      chk($sformatf("vec%0d_cp", i), bus.code_point, vecs[i].exp_cp);
    end

    // reset is the only way out of ERROR and discards a partial sequence
    step(1, 0, 8'hE2);
    do_reset();
    step(1, 0, 8'h41);
    step(0, 0, 8'h00);
    chk("post_reset_ready", {19'd0, bus.status}, 21'd2);
    chk("post_reset_cp", bus.code_point, 21'h41);

    bad_seq[0] = '{8'hC0, 8'h80, 8'h00, 8'h00}; bad_len[0] = 2;
    bad_seq[1] = '{8'hE0, 8'h80, 8'h80, 8'h00}; bad_len[1] = 3;
    bad_seq[2] = '{8'hED, 8'hA0, 8'h80, 8'h00}; bad_len[2] = 3;
    bad_seq[3] = '{8'hF4, 8'h90, 8'h80, 8'h80}; bad_len[3] = 4;
    bad_seq[4] = '{8'h80, 8'h00, 8'h00, 8'h00}; bad_len[4] = 1;
    bad_seq[5] = '{8'hE2, 8'h41, 8'h00, 8'h00}; bad_len[5] = 2;
    for (int c = 0; c < 6; c++) begin
      do_reset();
      for (int b = 0; b < bad_len[c]; b++) step(1, 0, bad_seq[c][b]);
      step(0, 0, 8'h00);
      step(0, 0, 8'h00);
      chk($sformatf("bad%0d_status", c), {19'd0, bus.status}, 21'd3);
      step(1, 0, 8'h41);
      step(0, 0, 8'h00);
      step(0, 0, 8'h00);
      chk($sformatf("bad%0d_stuck", c), {19'd0, bus.status}, 21'd3);
      chk($sformatf("bad%0d_cp", c), bus.code_point, 21'd0);
    end

    // the same ranges with legal second bytes must decode
    do_reset();
    step(1, 0, 8'hF4); step(1, 0, 8'h8F); step(1, 0, 8'hBF); step(1, 0, 8'hBF);
    step(0, 0, 8'h00);
    chk("max_cp_status", {19'd0, bus.status}, 21'd2);
    chk("max_cp", bus.code_point, 21'h10FFFF);
    step(1, 0, 8'hED); step(1, 0, 8'h9F); step(1, 1, 8'hBF);
    step(0, 0, 8'h00);
    chk("ed_hi_status", {19'd0, bus.status}, 21'd2);
    chk("ed_hi_cp", bus.code_point, 21'hD7FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
